// File: rtl/alu_pkg.sv
// Shared encodings for the iterative ALU: operation codes, control FSM states
// and bit positions within the {N,Z,C,V} flags vector.
package alu_pkg;

   typedef enum logic [2:0] {
      OpAdd  = 3'b000,
      OpSub  = 3'b001,
      OpAdc  = 3'b010,
      OpSbc  = 3'b011,
      OpMulu = 3'b100,
      OpMuls = 3'b101,
      OpDivu = 3'b110,
      OpDivs = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StDone = 2'b10
   } state_e;

   localparam int unsigned FlagN = 3;
   localparam int unsigned FlagZ = 2;
   localparam int unsigned FlagC = 1;
   localparam int unsigned FlagV = 0;

   // Multiply and divide share the upper half of the opcode space.
   function automatic logic op_is_iter(op_e op);
      return op[2];
   endfunction

   function automatic logic op_is_div(op_e op);
      return op[2] & op[1];
   endfunction

   function automatic logic op_is_signed(op_e op);
      return op[0];
   endfunction

endpackage

// File: rtl/iter_muldiv_core.sv
// Shift-add multiplier and restoring divider sharing one pair of shift registers.
// Signed ops run on magnitudes; sign correction is applied to the stepped values.
module iter_muldiv_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             is_div_i,
   input  logic             is_signed_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] res1_o,
   output logic [WIDTH-1:0] res2_o,
   output logic [3:0]       flags_o
);

   localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] hi_q, lo_q, mag_q, dividend_q;
   logic             is_div_q, neg_res_q, neg_rem_q, dzero_q, ovf_q;

   logic             neg_a, neg_b;
   logic [WIDTH-1:0] mag_a, mag_b;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] hi_s, lo_s;

   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   quo, rem;

   assign neg_a = is_signed_i & a_i[WIDTH-1];
   assign neg_b = is_signed_i & b_i[WIDTH-1];
   assign mag_a = neg_a ? -a_i : a_i;
   assign mag_b = neg_b ? -b_i : b_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hi_q       <= '0;
         lo_q       <= '0;
         mag_q      <= '0;
         dividend_q <= '0;
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         dzero_q    <= 1'b0;
         ovf_q      <= 1'b0;
      end else if (load_i) begin
         // Multiply: lo holds the multiplier; divide: lo holds the dividend/quotient.
         hi_q       <= '0;
         lo_q       <= is_div_i ? mag_a : mag_b;
         mag_q      <= is_div_i ? mag_b : mag_a;
         dividend_q <= a_i;
         is_div_q   <= is_div_i;
         neg_res_q  <= neg_a ^ neg_b;
         neg_rem_q  <= neg_a;
         dzero_q    <= (b_i == '0);
         ovf_q      <= is_signed_i & (a_i == MinNeg) & (b_i == '1);
      end else if (step_i) begin
         hi_q <= hi_s;
         lo_q <= lo_s;
      end
   end

   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
      div_shift = {hi_q, lo_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, mag_q});
      div_diff  = div_shift[WIDTH-1:0] - mag_q;
      if (is_div_q) begin
         hi_s = div_ge ? div_diff : div_shift[WIDTH-1:0];
         lo_s = {lo_q[WIDTH-2:0], div_ge};
      end else begin
         hi_s = mul_sum[WIDTH:1];
         lo_s = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
   end

   // Results reflect the step being taken this cycle, so the top can capture
   // them on the final RUN edge and present them during DONE.
   always_comb begin
      prod     = {hi_s, lo_s};
      prod_fix = neg_res_q ? -prod : prod;
      quo      = neg_res_q ? -lo_s : lo_s;
      rem      = neg_rem_q ? -hi_s : hi_s;
      flags_o  = '0;
      if (is_div_q) begin
         if (dzero_q) begin
            res1_o = '1;
            res2_o = dividend_q;
         end else begin
            res1_o = quo;
            res2_o = rem;
         end
         flags_o[FlagN] = res1_o[WIDTH-1];
         flags_o[FlagZ] = (res1_o == '0);
         flags_o[FlagV] = dzero_q | ovf_q;
      end else begin
         res1_o         = prod_fix[WIDTH-1:0];
         res2_o         = prod_fix[2*WIDTH-1:WIDTH];
         flags_o[FlagN] = prod_fix[2*WIDTH-1];
         flags_o[FlagZ] = (prod_fix == '0);
      end
   end

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle ALU: single-cycle add/sub family, WIDTH-cycle multiply/divide.
// Results are registered and held until the next operation completes.
module iter_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] Operand1,
   input  logic [WIDTH-1:0] Operand2,
   input  logic             C_In,
   output logic [WIDTH-1:0] Result1,
   output logic [WIDTH-1:0] Result2,
   output logic [3:0]       Flags,
   output logic             Busy,
   output logic             Done
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] res1_q, res1_d, res2_q, res2_d;
   logic [3:0]       flags_q, flags_d;
   logic             res_we;

   op_e              op_sel;
   logic             accept;
   logic             b_inv, cin;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic [3:0]       add_flags;

   logic [WIDTH-1:0] core_res1, core_res2;
   logic [3:0]       core_flags;

   assign op_sel = op_e'(Op);
   assign accept = Start & ((state_q == StIdle) | (state_q == StDone));

   always_comb begin
      b_inv = 1'b0;
      cin   = 1'b0;
      unique case (op_sel)
         OpSub: begin
            b_inv = 1'b1;
            cin   = 1'b1;
         end
         OpAdc: cin = C_In;
         OpSbc: begin
            b_inv = 1'b1;
            cin   = C_In;
         end
         default: ;
      endcase
      b_eff = b_inv ? ~Operand2 : Operand2;
      sum   = {1'b0, Operand1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
      add_flags        = '0;
      add_flags[FlagN] = sum[WIDTH-1];
      add_flags[FlagZ] = (sum[WIDTH-1:0] == '0);
      add_flags[FlagC] = sum[WIDTH];
      // Overflow: both addends share a sign that the sum does not.
      add_flags[FlagV] = (Operand1[WIDTH-1] == b_eff[WIDTH-1]) &
                         (sum[WIDTH-1] != Operand1[WIDTH-1]);
   end

   iter_muldiv_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk_i      (CLK),
      .rst_i      (RESET),
      .load_i     (accept & op_is_iter(op_sel)),
      .step_i     (state_q == StRun),
      .is_div_i   (op_is_div(op_sel)),
      .is_signed_i(op_is_signed(op_sel)),
      .a_i        (Operand1),
      .b_i        (Operand2),
      .res1_o     (core_res1),
      .res2_o     (core_res2),
      .flags_o    (core_flags)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      res_we  = 1'b0;
      res1_d  = core_res1;
      res2_d  = core_res2;
      flags_d = core_flags;
      unique case (state_q)
         StIdle, StDone: begin
            if (accept) begin
               if (op_is_iter(op_sel)) begin
                  state_d = StRun;
                  cnt_d   = '0;
               end else begin
                  state_d = StDone;
                  res_we  = 1'b1;
                  res1_d  = sum[WIDTH-1:0];
                  res2_d  = '0;
                  flags_d = add_flags;
               end
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = StDone;
               res_we  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         res1_q  <= '0;
         res2_q  <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (res_we) begin
            res1_q  <= res1_d;
            res2_q  <= res2_d;
            flags_q <= flags_d;
         end
      end
   end

   assign Result1 = res1_q;
   assign Result2 = res2_q;
   assign Flags   = flags_q;
   assign Busy    = (state_q == StRun);
   assign Done    = (state_q == StDone);

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: directed corner cases plus randomized ops
// compared against an arithmetic reference model.
module tb_iter_alu;

   localparam int unsigned W = 32;
   localparam longint SMax = 64'sd2147483647;
   localparam longint SMin = -64'sd2147483648;

   logic          clk = 1'b0;
   logic          reset, start, c_in;
   logic [2:0]    op;
   logic [W-1:0]  a, b, r1, r2;
   logic [3:0]    flags;
   logic          busy, done;
   int            checks = 0;
   int            failures = 0;

   always #5 clk = ~clk;

   iter_alu #(.WIDTH(W)) dut (
      .CLK(clk), .RESET(reset), .Start(start), .Op(op), .Operand1(a), .Operand2(b),
      .C_In(c_in), .Result1(r1), .Result2(r2), .Flags(flags), .Busy(busy), .Done(done)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (time %0t, limit 2000000)", $time);
      $fatal(1);
   end

   task automatic model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                        input logic mc, output logic [31:0] e1, output logic [31:0] e2,
                        output logic [3:0] ef);
      longint       sa, sb, sx, sr;
      logic [63:0]  ux, p;
      logic [31:0]  bb;
      logic         ci;
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      if (mop[2] == 1'b0) begin
         bb = mop[0] ? ~mb : mb;
         ci = (mop == 3'd0) ? 1'b0 : (mop == 3'd1) ? 1'b1 : mc;
         ux = {32'b0, ma} + {32'b0, bb} + {63'b0, ci};
         case (mop)
            3'd0:    sx = sa + sb;
            3'd1:    sx = sa - sb;
            3'd2:    sx = sa + sb + longint'(ci);
            default: sx = sa - sb - 1 + longint'(ci);
         endcase
         e1 = ux[31:0];
         e2 = '0;
         ef = {e1[31], e1 == 0, ux[32], (sx > SMax) || (sx < SMin)};
      end else if (mop[1] == 1'b0) begin
         if (mop[0]) p = sa * sb;
         else        p = {32'b0, ma} * {32'b0, mb};
         e1 = p[31:0];
         e2 = p[63:32];
         ef = {p[63], p == 0, 2'b00};
      end else if (mb == 0) begin
         e1 = '1;
         e2 = ma;
         ef = 4'b1001;
      end else begin
         if (mop[0]) begin
            sx = sa / sb;
            sr = sa % sb;
         end else begin
            sx = longint'({32'b0, ma} / {32'b0, mb});
            sr = longint'({32'b0, ma} % {32'b0, mb});
         end
         e1 = sx[31:0];
         e2 = sr[31:0];
         ef = {e1[31], e1 == 0, 1'b0, sx > SMax};
      end
   endtask

   // Wait for Done, counting cycles from acceptance and Busy cycles seen.
   task automatic wait_done(output int lat, output int nbusy);
      lat = 1;
      nbusy = 0;
      while (done !== 1'b1 && lat <= int'(W) + 4) begin
         if (busy === 1'b1) nbusy++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic ci);
      logic [31:0] e1, e2;
      logic [3:0]  ef;
      int          lat, nbusy;
      model(o, x, y, ci, e1, e2, ef);
      @(negedge clk);
      op = o; a = x; b = y; c_in = ci; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      op = 3'($urandom); a = $urandom; b = $urandom; c_in = 1'($urandom);
      wait_done(lat, nbusy);
      checks++;
      if (lat !== (o[2] ? int'(W) + 1 : 1))
         $display("FAIL %s latency: got %0d want %0d", name, lat, o[2] ? W + 1 : 1);
      if (lat !== (o[2] ? int'(W) + 1 : 1)) failures++;
      checks++;
      if (nbusy !== (o[2] ? int'(W) : 0)) begin
         $display("FAIL %s busy cycles: got %0d want %0d", name, nbusy, o[2] ? W : 0);
         failures++;
      end
      checks++;
      if ({r1, r2, flags} !== {e1, e2, ef}) begin
         $display("FAIL %s result: got r1=%h r2=%h f=%b want r1=%h r2=%h f=%b",
                  name, r1, r2, flags, e1, e2, ef);
         failures++;
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || {r1, r2, flags} !== {e1, e2, ef}) begin
         $display("FAIL %s hold: got done=%b r1=%h r2=%h f=%b want done=0 r1=%h r2=%h f=%b",
                  name, done, r1, r2, flags, e1, e2, ef);
         failures++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; op = 3'd0; a = 32'h1234; b = 32'h1; c_in = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({r1, r2, flags, busy, done} !== '0) begin
         $display("FAIL reset: got r1=%h r2=%h f=%b busy=%b done=%b want all zero",
                  r1, r2, flags, busy, done);
         failures++;
      end
      reset = 1'b0; start = 1'b0;
   endtask

   task automatic test_directed();
      run_op("adc_wrap", 3'd2, 32'hFFFF_FFFF, 32'h0, 1'b1);
      run_op("sub_ovf", 3'd1, 32'h8000_0000, 32'h1, 1'b0);
      run_op("muls_neg", 3'd5, 32'hFFFF_FFFE, 32'h3, 1'b0);
      run_op("divs_neg", 3'd7, 32'hFFFF_FFF9, 32'h2, 1'b0);
      run_op("divu_zero", 3'd6, 32'd100, 32'h0, 1'b0);
      run_op("divs_zero", 3'd7, 32'h8000_0005, 32'h0, 1'b0);
      run_op("divs_minneg", 3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op("mulu_max", 3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op("muls_min", 3'd5, 32'h8000_0000, 32'h8000_0000, 1'b0);
      run_op("sbc_borrow", 3'd3, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic test_random();
      logic [2:0]  o;
      logic [31:0] x, y;
      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 7));
         x = $urandom;
         y = $urandom;
         if (i % 4 == 1) y = y >> $urandom_range(8, 31);
         if (i % 9 == 0) y = '0;
         run_op("random", o, x, y, 1'($urandom));
      end
   endtask

   task automatic test_reset_abort();
      int saw_done = 0;
      @(negedge clk);
      op = 3'd6; a = 32'd1000; b = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({r1, r2, flags, busy, done} !== '0) begin
         $display("FAIL abort_clear: got r1=%h r2=%h f=%b busy=%b done=%b want all zero",
                  r1, r2, flags, busy, done);
         failures++;
      end
      for (int i = 0; i < int'(W) + 4; i++) begin
         if (done === 1'b1 || busy === 1'b1) saw_done++;
         @(negedge clk);
      end
      checks++;
      if (saw_done !== 0) begin
         $display("FAIL abort_no_done: got %0d active cycles want 0", saw_done);
         failures++;
      end
      run_op("mulu_after_reset", 3'd4, 32'd6, 32'd7, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] e1, e2, g1, g2, x1, y1, x2, y2;
      logic [3:0]  ef, gf;
      int          lat, nbusy;
      x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom >> 4;
      @(negedge clk);
      op = 3'd4; a = x1; b = y1; start = 1'b1;
      @(negedge clk);
      op = 3'd7; a = x2; b = y2;
      wait_done(lat, nbusy);
      model(3'd4, x1, y1, 1'b0, e1, e2, ef);
      checks++;
      if (lat !== int'(W) + 1 || nbusy !== int'(W) || {r1, r2, flags} !== {e1, e2, ef}) begin
         $display("FAIL b2b_first: got lat=%0d busy=%0d r1=%h r2=%h f=%b want lat=%0d busy=%0d r1=%h r2=%h f=%b",
                  lat, nbusy, r1, r2, flags, W + 1, W, e1, e2, ef);
         failures++;
      end
      @(negedge clk);
      start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
      wait_done(lat, nbusy);
      model(3'd7, x2, y2, 1'b0, e1, e2, ef);
      checks++;
      if (lat !== int'(W) + 1 || {r1, r2, flags} !== {e1, e2, ef}) begin
         $display("FAIL b2b_second: got lat=%0d r1=%h r2=%h f=%b want lat=%0d r1=%h r2=%h f=%b",
                  lat, r1, r2, flags, W + 1, e1, e2, ef);
         failures++;
      end
      // Single-cycle ops chained with Start held high: Done every cycle.
      @(negedge clk);
      op = 3'd0; a = x1; b = y1; c_in = 1'b0; start = 1'b1;
      @(negedge clk);
      g1 = r1; gf = flags;
      op = 3'd1; a = x2; b = y2;
      model(3'd0, x1, y1, 1'b0, e1, e2, ef);
      checks++;
      if (done !== 1'b1 || {g1, gf} !== {e1, ef}) begin
         $display("FAIL b2b_add: got done=%b r1=%h f=%b want done=1 r1=%h f=%b",
                  done, g1, gf, e1, ef);
         failures++;
      end
      @(negedge clk);
      start = 1'b0;
      g2 = r1; gf = flags;
      model(3'd1, x2, y2, 1'b0, e1, e2, ef);
      checks++;
      if (done !== 1'b1 || {g2, gf} !== {e1, ef}) begin
         $display("FAIL b2b_sub: got done=%b r1=%h f=%b want done=1 r1=%h f=%b",
                  done, g2, gf, e1, ef);
         failures++;
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_reset_abort();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
